onehot_encoder_seq: RTL



---
 rtl/onehot_encoder_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/onehot_encoder_seq.sv
// Sequential bit-scan encoder: accepts a WIDTH-bit vector and emits the index of each set bit, one per beat.
// Optional macro ONEHOT_ENCODER_ZERO_BEAT_EN makes an all-zero vector produce a single out_zero beat.
module onehot_encoder_seq #(
  parameter int WIDTH = 8,
  parameter int LSB_FIRST = 1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends combinationally on ready, and beat fields hold while valid && !ready.
  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_mask;
  logic             single_bit;
  logic             last_beat;

`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
  logic zero_q, zero_d;
`else
  localparam logic zero_q = 1'b0;
`endif

  // Priority pick works on registered pending only, so no input reaches the outputs combinationally.
  always_comb begin
    sel_idx  = '0;
    sel_mask = '0;
    if (LSB_FIRST != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) begin
          sel_idx     = IDX_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) begin
          sel_idx     = IDX_W'(i);
          sel_mask    = '0;
          sel_mask[i] = 1'b1;
        end
      end
    end
  end

  assign single_bit = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign last_beat  = single_bit | zero_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
    zero_d    = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_data;
          if (in_data != '0) begin
            state_d = BUSY;
          end
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
          else begin
            state_d = BUSY;
            zero_d  = 1'b1;
          end
`endif
        end
      end
      BUSY: begin
        if (out_ready) begin
          pending_d = pending_q & ~sel_mask;
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
          zero_d    = 1'b0;
`endif
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
      zero_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
`ifdef ONEHOT_ENCODER_ZERO_BEAT_EN
      zero_q    <= zero_d;
`endif
    end
  end

  // pending is always zero in IDLE, so idx/last read 0 there without extra gating.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == BUSY);
  assign out_idx   = sel_idx;
  assign out_last  = last_beat;
  assign out_zero  = zero_q;

endmodule
